// File: rtl/uart_host_master.sv
// uart_host_master: host-side initiator for the UART memory-access bridge.
// Serialises req/gnt word accesses into bridge bytes and checks the echoes.
module uart_host_master #(
  parameter int         ADDR_WIDTH     = 13,
  parameter logic [7:0] PROMPT_BYTE    = 8'h20,
  parameter int         TIMEOUT_CYCLES = 2000000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  tx_start_o,
  output logic [7:0]            tx_byte_o,
  input  logic                  tx_busy_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_byte_i,
  input  logic                  rx_error_i
);

  localparam logic [7:0] WRITE_CMD = 8'h41;
  localparam logic [7:0] READ_CMD  = 8'h42;
  localparam logic [7:0] ALIVE     = 8'h20;
  localparam int         TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    SEND_CMD,
    WAIT_CMD_ECHO,
    SEND_AH,
    WAIT_AH_ECHO,
    SEND_AL,
    WAIT_AL_ECHO,
    SEND_WD,
    WAIT_WD_ECHO,
    WAIT_RD,
    SEND_PROMPT,
    DRAIN,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic [2:0]            r_cnt;
  logic                  r_err;
  logic                  r_tx_start;
  logic [7:0]            r_tx_byte;
  logic [TW-1:0]         r_to_cnt;

  logic [12:0] w_addr13;
  logic        w_send;
  logic [7:0]  w_send_byte;
  logic        w_tx_go;
  logic        w_set_err;
  logic        w_latch;
  logic        w_wd_shift;
  logic        w_rd_shift;
  logic        w_in_wait;
  logic        w_timeout;
  logic        w_rx_ok;
  logic        w_echo_ok;

  assign w_addr13  = 13'(r_addr);
  assign w_rx_ok   = rx_valid_i && !rx_error_i;
  assign w_echo_ok = (rx_byte_i == r_tx_byte);
  assign w_timeout = (r_to_cnt == TO_LAST);
  assign w_in_wait = (r_state == WAIT_CMD_ECHO) ||
                     (r_state == WAIT_AH_ECHO)  ||
                     (r_state == WAIT_AL_ECHO)  ||
                     (r_state == WAIT_WD_ECHO)  ||
                     (r_state == WAIT_RD)       ||
                     (r_state == DRAIN);

  always_comb begin
    w_next      = r_state;
    w_send      = 1'b0;
    w_send_byte = 8'h00;
    w_set_err   = 1'b0;
    w_latch     = 1'b0;
    w_wd_shift  = 1'b0;
    w_rd_shift  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_i) begin
          w_latch = 1'b1;
          w_next  = SEND_CMD;
        end
      end
      SEND_CMD: begin
        w_send      = 1'b1;
        w_send_byte = r_we ? WRITE_CMD : READ_CMD;
        if (r_tx_start) w_next = WAIT_CMD_ECHO;
      end
      // The idle bridge keeps emitting ALIVE, so skip it here only
      WAIT_CMD_ECHO: begin
        if (w_rx_ok && rx_byte_i != ALIVE) begin
          if (w_echo_ok) begin
            w_next = SEND_AH;
          end else begin
            w_set_err = 1'b1;
            w_next    = RESP;
          end
        end
      end
      SEND_AH: begin
        w_send      = 1'b1;
        w_send_byte = {3'b011, w_addr13[12:8]};
        if (r_tx_start) w_next = WAIT_AH_ECHO;
      end
      WAIT_AH_ECHO: begin
        if (w_rx_ok) begin
          if (w_echo_ok) begin
            w_next = SEND_AL;
          end else begin
            w_set_err = 1'b1;
            w_next    = RESP;
          end
        end
      end
      SEND_AL: begin
        w_send      = 1'b1;
        w_send_byte = w_addr13[7:0];
        if (r_tx_start) w_next = r_we ? WAIT_AL_ECHO : WAIT_RD;
      end
      WAIT_AL_ECHO: begin
        if (w_rx_ok) begin
          if (w_echo_ok) begin
            w_next = SEND_WD;
          end else begin
            w_set_err = 1'b1;
            w_next    = RESP;
          end
        end
      end
      SEND_WD: begin
        w_send      = 1'b1;
        w_send_byte = r_wdata[31:24];
        if (r_tx_start) w_next = WAIT_WD_ECHO;
      end
      WAIT_WD_ECHO: begin
        if (w_rx_ok) begin
          if (w_echo_ok) begin
            w_wd_shift = 1'b1;
            w_next     = (r_cnt == 3'd3) ? RESP : SEND_WD;
          end else begin
            w_set_err = 1'b1;
            w_next    = RESP;
          end
        end
      end
      WAIT_RD: begin
        if (w_rx_ok) begin
          w_rd_shift = 1'b1;
          w_next     = SEND_PROMPT;
        end
      end
      // The fourth prompt idles the bridge, which then repeats byte 4
      SEND_PROMPT: begin
        w_send      = 1'b1;
        w_send_byte = PROMPT_BYTE;
        if (r_tx_start) w_next = (r_cnt == 3'd4) ? DRAIN : WAIT_RD;
      end
      DRAIN: begin
        if (w_rx_ok) w_next = RESP;
      end
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_in_wait) begin
      if (rx_valid_i && rx_error_i) begin
        w_set_err = 1'b1;
        w_next    = RESP;
      end else if (!rx_valid_i && w_timeout) begin
        w_set_err = 1'b1;
        w_next    = RESP;
      end
    end
  end

  assign w_tx_go = w_send && !r_tx_start && !tx_busy_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_start <= 1'b0;
      r_tx_byte  <= 8'h00;
    end else begin
      r_tx_start <= w_tx_go;
      if (w_tx_go) r_tx_byte <= w_send_byte;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_cnt   <= 3'd0;
    end else if (w_latch) begin
      r_we    <= we_i;
      r_addr  <= addr_i;
      r_wdata <= wdata_i;
      r_rdata <= 32'h0;
      r_cnt   <= 3'd0;
    end else if (w_wd_shift) begin
      r_wdata <= {r_wdata[23:0], 8'h00};
      r_cnt   <= r_cnt + 3'd1;
    end else if (w_rd_shift) begin
      r_rdata <= {r_rdata[23:0], rx_byte_i};
      r_cnt   <= r_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                   r_to_cnt <= '0;
    else if (!w_in_wait)           r_to_cnt <= '0;
    else if (rx_valid_i)           r_to_cnt <= '0;
    else if (r_to_cnt != {TW{1'b1}}) r_to_cnt <= r_to_cnt + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               r_err <= 1'b0;
    else if (r_state == RESP)  r_err <= 1'b0;
    else if (w_set_err)        r_err <= 1'b1;
  end

  assign gnt_o      = rst_ni && (r_state == IDLE) && req_i;
  assign rvalid_o   = (r_state == RESP);
  assign err_o      = rvalid_o && r_err;
  assign rdata_o    = (rvalid_o && !r_err && !r_we) ? r_rdata : 32'h0;
  assign tx_start_o = r_tx_start;
  assign tx_byte_o  = r_tx_byte;

endmodule

// File: doc/uart_host_master.md
Name: uart_host_master

Overview:
- Host-side initiator for the UART memory-access protocol; it is the far end of the on-chip UART-to-memory bridge.
- Accepts single-word read/write requests on an ibex-style req/gnt local port, serializes them into command/address/data bytes, and checks the bridge's echoes.
- Collects read data and returns one response per request.
- Sits between a test/debug controller and a byte-level uart core (tx start/byte, rx valid/byte/error).

Parameters:
- ADDR_WIDTH, 13, word address width; bits [12:8] go in the address-head byte, bits [7:0] in the address-tail byte.
- PROMPT_BYTE, 8'h20, byte sent to pull each subsequent read-data byte.
- TIMEOUT_CYCLES, 2000000, maximum clk_i cycles spent waiting for any single rx byte.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  request valid; held until gnt_o
- we_i  in  1  1 = write, 0 = read
- addr_i  in  ADDR_WIDTH  word address
- wdata_i  in  32  write data
- gnt_o  out  1  one-cycle request accept
- rvalid_o  out  1  one-cycle completion, for both reads and writes
- rdata_o  out  32  read data; valid with rvalid_o
- err_o  out  1  error flag; valid with rvalid_o
- tx_start_o  out  1  one-cycle transmit pulse to the uart core
- tx_byte_o  out  8  byte to transmit
- tx_busy_i  in  1  uart transmitter busy
- rx_valid_i  in  1  one-cycle received-byte strobe
- rx_byte_i  in  8  received byte
- rx_error_i  in  1  receive framing/parity error; qualified by rx_valid_i

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters cleared.
  - Reset asserted mid-transaction aborts it immediately.
  - No response is issued for an aborted request.
- Protocol constants:
  - WRITE_CMD = 8'h41, READ_CMD = 8'h42.
  - ADDR_HEAD = {3'b011, addr[12:8]}, ADDR_TAIL = addr[7:0].
  - ALIVE = 8'h20.
- IDLE:
  - gnt_o=1 for one cycle when req_i=1; latch we_i, addr_i, wdata_i in that cycle.
  - Go to SEND_CMD.
  - gnt_o stays 0 in every other state.
- Transmit rule (all SEND_* states):
  - tx_start_o pulses for exactly one cycle, only when tx_busy_i=0 and tx_start_o was 0 in the previous cycle.
  - tx_byte_o is stable from the pulse until the next pulse.
  - The state advances in the cycle after the pulse.
- Write sequence:
  - SEND_CMD(41) -> WAIT_CMD_ECHO
  - SEND_AH -> WAIT_AH_ECHO
  - SEND_AL -> WAIT_AL_ECHO
  - 4 x (SEND_WD -> WAIT_WD_ECHO), data MSB first: [31:24], [23:16], [15:8], [7:0]
  - -> RESP
- Read sequence:
  - SEND_CMD(42) -> WAIT_CMD_ECHO
  - SEND_AH -> WAIT_AH_ECHO
  - SEND_AL -> WAIT_RD. The bridge does not echo the tail on reads.
  - Each byte received in WAIT_RD shifts into rdata, MSB first; the byte counter increments.
  - After bytes 1-3: SEND_PROMPT(PROMPT_BYTE) -> WAIT_RD.
  - After byte 4: SEND_PROMPT -> DRAIN. The terminating prompt makes the bridge return to idle and resend byte 4.
  - DRAIN discards the next received byte -> RESP.
- Echo checking:
  - In WAIT_* echo states, rx_byte_i must equal the byte just sent; a mismatch sets the error and goes to RESP.
  - WAIT_CMD_ECHO only: 8'h20 bytes are ignored and do not count as a mismatch, because the bridge emits ALIVE while idle.
  - In all other wait states, 8'h20 is ordinary data.
- rx_error_i with rx_valid_i in any wait state: set the error and go to RESP.
- rx_valid_i outside wait states is ignored.
- Timeout:
  - A per-wait counter clears on entry to each wait state and on each accepted byte.
  - Reaching TIMEOUT_CYCLES-1 sets the error and goes to RESP.
  - Width is clog2(TIMEOUT_CYCLES); the counter saturates and never wraps.
- RESP:
  - rvalid_o=1 for one cycle.
  - err_o = error flag.
  - rdata_o = assembled word for a good read; 0 for writes and for any error.
  - Then go to IDLE; the error flag clears.
- Back-to-back requests: earliest next gnt_o is the cycle after rvalid_o.

Test Plan:
- Write addr=0x0ABC, wdata=0xDEADBEEF, bridge model echoes every byte -> tx sequence 41, 6A, BC, DE, AD, BE, EF; rvalid_o=1, err_o=0, exactly 7 tx_start_o pulses.
- Read addr=0x1234, bridge returns 11, 22, 33, 44, then resends 44 -> tx sequence 42, 72, 34, 20, 20, 20, 20; rdata_o=0x11223344, err_o=0.
- Bridge sends 20, 20 before echoing 41 -> both ignored, transaction completes with err_o=0; a write with wdata=0x20202020 also completes with err_o=0.
- Address-head echo returns 0x73 instead of 0x72 -> rvalid_o with err_o=1, rdata_o=0, no further tx_start_o pulses.
- No echo after the command, TIMEOUT_CYCLES=100 -> err_o=1 exactly 100 cycles after WAIT_CMD_ECHO entry; an rx_error_i strobe during read byte 2 -> err_o=1.
- rst_ni pulsed low during write data byte 2 -> all outputs 0 asynchronously; a fresh request afterwards completes normally.
